// File: rtl/dm_store_buffer_pkg.sv
// Shared definitions for the data-memory store path: memory op encodings
// (common with the load extender) and the store FIFO entry layout.
package dm_store_buffer_pkg;

  typedef enum logic [2:0] {
    MEM_OP_W = 3'b000,
    MEM_OP_B = 3'b010,
    MEM_OP_H = 3'b100
  } mem_op_e;

  typedef struct packed {
    logic [29:0] word;
    logic [31:0] wdata;
    logic [3:0]  be;
  } sb_entry_t;

  function automatic logic [31:0] word_addr(input logic [29:0] word);
    return {word, 2'b00};
  endfunction

endpackage

// File: rtl/dm_store_buffer_if.sv
// Bundle of the MEM-stage store/load ports and the data-memory write port
// seen by the store buffer.
interface dm_store_buffer_if;
  // st_valid/st_ready: a store transfers on any cycle both are high; mem_req/mem_ack:
  // the head entry is consumed on any cycle both are high and is held stable otherwise.
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_op;
  logic        st_err;
  logic [31:0] st_err_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        buf_empty;

  modport slave (
    input  st_valid, st_addr, st_data, st_op, mem_ack, ld_valid, ld_addr,
    output st_ready, st_err, st_err_addr, mem_req, mem_addr, mem_wdata, mem_be,
           ld_hazard, buf_empty
  );

  modport master (
    output st_valid, st_addr, st_data, st_op, mem_ack, ld_valid, ld_addr,
    input  st_ready, st_err, st_err_addr, mem_req, mem_addr, mem_wdata, mem_be,
           ld_hazard, buf_empty
  );
endinterface

// File: rtl/dm_store_align.sv
// Combinational store aligner: replicates sb/sh data across the word and
// derives byte enables; flags misaligned addresses and unknown ops.
module dm_store_align
  import dm_store_buffer_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_data,
  input  logic [2:0]  i_op,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_be,
  output logic        o_illegal
);

  always_comb begin
    o_wdata   = i_data;
    o_be      = 4'b0000;
    o_illegal = 1'b1;
    case (i_op)
      MEM_OP_B: begin
        o_wdata   = {4{i_data[7:0]}};
        o_be      = 4'b0001 << i_addr_lo;
        o_illegal = 1'b0;
      end
      MEM_OP_H: begin
        o_wdata   = {2{i_data[15:0]}};
        o_be      = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_illegal = i_addr_lo[0];
      end
      MEM_OP_W: begin
        o_wdata   = i_data;
        o_be      = 4'b1111;
        o_illegal = (i_addr_lo != 2'b00);
      end
      default: begin
        o_wdata   = i_data;
        o_be      = 4'b0000;
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dm_store_buffer.sv
// Store buffer between the MEM stage and the data-memory write port: aligns
// stores, queues them in a small FIFO, drains over req/ack and flags hazards.
module dm_store_buffer
  import dm_store_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dm_store_buffer_if.slave       bus,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t          r_mem [DEPTH];
  logic [DEPTH-1:0]   r_valid;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_st_err;
  logic [31:0]        r_st_err_addr;

  logic [31:0] w_wdata;
  logic [3:0]  w_be;
  logic        w_illegal;
  logic        w_full;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_hazard;
  sb_entry_t   w_head;
  logic        w_unused_ld;

  dm_store_align u_align (
    .i_addr_lo (bus.st_addr[1:0]),
    .i_data    (bus.st_data),
    .i_op      (bus.st_op),
    .o_wdata   (w_wdata),
    .o_be      (w_be),
    .o_illegal (w_illegal)
  );

  // No push-through when full: st_ready depends only on the registered count.
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_accept = bus.st_valid & ~w_full;
  assign w_push   = w_accept & ~w_illegal;
  assign w_pop    = (r_count != '0) & bus.mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_valid       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_st_err      <= 1'b0;
      r_st_err_addr <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr]   <= '{word: bus.st_addr[31:2], wdata: w_wdata, be: w_be};
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_st_err <= w_accept & w_illegal;
      if (w_accept & w_illegal) r_st_err_addr <= bus.st_addr;
    end
  end

  // Hazard is word-granular; the byte offset of the load is irrelevant.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_mem[i].word == bus.ld_addr[31:2])) w_hazard = 1'b1;
    end
  end

  assign w_unused_ld = ^bus.ld_addr[1:0];
  assign w_head      = r_mem[r_rd_ptr];

  assign bus.st_ready    = ~w_full;
  assign bus.st_err      = r_st_err;
  assign bus.st_err_addr = r_st_err_addr;
  assign bus.mem_req     = (r_count != '0);
  assign bus.mem_addr    = word_addr(w_head.word);
  assign bus.mem_wdata   = w_head.wdata;
  assign bus.mem_be      = w_head.be;
  assign bus.ld_hazard   = bus.ld_valid & w_hazard;
  assign bus.buf_empty   = (r_count == '0);
  assign o_count         = r_count;

endmodule

// File: tb/tb_dm_store_buffer.sv
// Self-checking bench for dm_store_buffer: alignment vector table, directed
// multi-cycle sequences, then randomized traffic against a queue model.
module tb_dm_store_buffer;
  import dm_store_buffer_pkg::*;

  localparam int DEPTH = 2;

  logic       clk;
  logic       rst_n;
  logic [1:0] count;
  int         n_checks;
  int         n_fail;

  dm_store_buffer_if bus ();

  dm_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .o_count (count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_st(input logic v, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] d);
    bus.st_valid = v;
    bus.st_op    = op;
    bus.st_addr  = a;
    bus.st_data  = d;
  endtask

  task automatic idle_inputs();
    drive_st(1'b0, 3'b000, 32'h0, 32'h0);
    bus.mem_ack  = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_addr  = 32'h0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [2:0] op);
    if (op == 3'b010) return 1;
    if (op == 3'b100) return 2;
    if (op == 3'b000) return 4;
    return 0;
  endfunction

  function automatic logic model_legal(input logic [2:0] op, input logic [31:0] a);
    int sz;
    sz = op_size(op);
    return (sz != 0) && ((a % sz) == 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] op, input logic [31:0] a);
    int sz;
    int m;
    sz = op_size(op);
    m  = ((1 << sz) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] d);
    int sz;
    logic [31:0] w;
    sz = op_size(op);
    w  = '0;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = d[8*(b % sz) +: 8];
    return w;
  endfunction

  // Scoreboard: {mem_addr, wdata, be}
  logic [67:0] exp_q[$];
  logic        m_err;
  logic [31:0] m_err_addr;

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    logic [3:0]  be;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vec_t   v;
    logic   hz;
    logic   acc;
    logic   r_stv;
    logic [2:0]  r_op;
    logic [31:0] r_a, r_d;
    int     sel;

    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = '{3'b010, 32'h0000_1003, 32'h0000_00AB, 1'b0, 4'b1000, 32'hABAB_ABAB};
    vecs[1]  = '{3'b010, 32'h0000_1000, 32'h1234_5678, 1'b0, 4'b0001, 32'h7878_7878};
    vecs[2]  = '{3'b010, 32'h0000_1001, 32'h0000_00FF, 1'b0, 4'b0010, 32'hFFFF_FFFF};
    vecs[3]  = '{3'b100, 32'h0000_2002, 32'h0000_1234, 1'b0, 4'b1100, 32'h1234_1234};
    vecs[4]  = '{3'b100, 32'h0000_2000, 32'hCAFE_BEEF, 1'b0, 4'b0011, 32'hBEEF_BEEF};
    vecs[5]  = '{3'b100, 32'h0000_2001, 32'h0000_5555, 1'b1, 4'b0000, 32'h0};
    vecs[6]  = '{3'b100, 32'h0000_2003, 32'h0000_5555, 1'b1, 4'b0000, 32'h0};
    vecs[7]  = '{3'b000, 32'h0000_2004, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'hDEAD_BEEF};
    vecs[8]  = '{3'b000, 32'h0000_3001, 32'h1111_1111, 1'b1, 4'b0000, 32'h0};
    vecs[9]  = '{3'b000, 32'h0000_3002, 32'h2222_2222, 1'b1, 4'b0000, 32'h0};
    vecs[10] = '{3'b111, 32'h0000_3000, 32'h3333_3333, 1'b1, 4'b0000, 32'h0};
    vecs[11] = '{3'b001, 32'h0000_3004, 32'h4444_4444, 1'b1, 4'b0000, 32'h0};

    // ---- reset state ----
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_st_err", bus.st_err, 0);
    chk("rst_st_err_addr", bus.st_err_addr, 0);
    chk("rst_buf_empty", bus.buf_empty, 1);
    chk("rst_st_ready", bus.st_ready, 1);
    chk("rst_count", count, 0);
    rst_n = 1'b1;

    // ---- alignment table: ack held high throughout ----
    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      @(negedge clk);
      bus.mem_ack = 1'b1;
      drive_st(1'b1, v.op, v.addr, v.data);
      #1 chk($sformatf("vec%0d_ready", i), bus.st_ready, 1);
      @(negedge clk);
      drive_st(1'b0, 3'b000, 32'h0, 32'h0);
      chk($sformatf("vec%0d_mem_req", i), bus.mem_req, !v.err);
      chk($sformatf("vec%0d_st_err", i), bus.st_err, v.err);
      if (v.err) begin
        chk($sformatf("vec%0d_err_addr", i), bus.st_err_addr, v.addr);
      end else begin
        chk($sformatf("vec%0d_mem_addr", i), bus.mem_addr, {v.addr[31:2], 2'b00});
        chk($sformatf("vec%0d_be", i), bus.mem_be, v.be);
        chk($sformatf("vec%0d_wdata", i), bus.mem_wdata, v.wdata);
      end
      @(negedge clk);
      bus.mem_ack = 1'b0;
      chk($sformatf("vec%0d_err_pulse", i), bus.st_err, 0);
      chk($sformatf("vec%0d_drained", i), bus.buf_empty, 1);
    end

    // ---- fill to full with ack low, then drain in order ----
    @(negedge clk);
    drive_st(1'b1, 3'b100, 32'h0000_2002, 32'h0000_1234);
    @(negedge clk);
    drive_st(1'b1, 3'b000, 32'h0000_2004, 32'hDEAD_BEEF);
    #1 chk("fill_ready_2nd", bus.st_ready, 1);
    @(negedge clk);
    drive_st(1'b0, 3'b000, 32'h0, 32'h0);
    chk("fill_ready_full", bus.st_ready, 0);
    chk("fill_count", count, 2);
    chk("fill_head_be", bus.mem_be, 4'b1100);
    chk("fill_head_wdata", bus.mem_wdata, 32'h1234_1234);
    @(negedge clk);
    chk("fill_hold_addr", bus.mem_addr, 32'h0000_2000);
    chk("fill_hold_wdata", bus.mem_wdata, 32'h1234_1234);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    chk("fill_2nd_addr", bus.mem_addr, 32'h0000_2004);
    chk("fill_2nd_be", bus.mem_be, 4'b1111);
    chk("fill_2nd_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("fill_2nd_ready", bus.st_ready, 1);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("fill_empty", bus.buf_empty, 1);
    chk("fill_req_low", bus.mem_req, 0);

    // ---- full + pop + store in same cycle: no push-through ----
    @(negedge clk);
    drive_st(1'b1, 3'b000, 32'h0000_5008, 32'h0000_0001);
    @(negedge clk);
    drive_st(1'b1, 3'b000, 32'h0000_500C, 32'h0000_0002);
    @(negedge clk);
    drive_st(1'b1, 3'b000, 32'h0000_5010, 32'h0000_0003);
    bus.mem_ack = 1'b1;
    #1 chk("pt_ready_full", bus.st_ready, 0);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("pt_count_after_pop", count, 1);
    chk("pt_head_after_pop", bus.mem_addr, 32'h0000_500C);
    #1 chk("pt_ready_retry", bus.st_ready, 1);
    @(negedge clk);
    drive_st(1'b0, 3'b000, 32'h0, 32'h0);
    chk("pt_count_accept", count, 2);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    chk("pt_tail_addr", bus.mem_addr, 32'h0000_5010);
    chk("pt_tail_wdata", bus.mem_wdata, 32'h0000_0003);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("pt_empty", bus.buf_empty, 1);

    // ---- load-after-store hazard ----
    @(negedge clk);
    drive_st(1'b1, 3'b000, 32'h0000_4000, 32'h0BAD_F00D);
    @(negedge clk);
    drive_st(1'b0, 3'b000, 32'h0, 32'h0);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 32'h0000_4002;
    #1 chk("hz_same_word", bus.ld_hazard, 1);
    bus.ld_addr = 32'h0000_4004;
    #1 chk("hz_next_word", bus.ld_hazard, 0);
    bus.ld_addr  = 32'h0000_4000;
    bus.ld_valid = 1'b0;
    #1 chk("hz_no_valid", bus.ld_hazard, 0);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack  = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 32'h0000_4002;
    #1 chk("hz_after_ack", bus.ld_hazard, 0);
    bus.ld_valid = 1'b0;

    // ---- async reset while a transfer and an error are pending ----
    @(negedge clk);
    drive_st(1'b1, 3'b000, 32'h0000_6000, 32'h6666_6666);
    @(negedge clk);
    drive_st(1'b1, 3'b000, 32'h0000_6001, 32'h7777_7777);
    @(negedge clk);
    drive_st(1'b0, 3'b000, 32'h0, 32'h0);
    chk("ar_pre_req", bus.mem_req, 1);
    chk("ar_pre_err", bus.st_err, 1);
    chk("ar_pre_err_addr", bus.st_err_addr, 32'h0000_6001);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_mem_req", bus.mem_req, 0);
    chk("ar_buf_empty", bus.buf_empty, 1);
    chk("ar_st_err", bus.st_err, 0);
    chk("ar_err_addr", bus.st_err_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- randomized traffic against the queue model ----
    pulse_reset();
    exp_q.delete();
    m_err      = 1'b0;
    m_err_addr = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      r_stv = ($urandom_range(0, 99) < 60);
      sel   = $urandom_range(0, 9);
      r_op  = (sel < 3) ? 3'b010 : (sel < 6) ? 3'b100 : (sel < 9) ? 3'b000 : 3'($urandom);
      r_a   = $urandom_range(0, 63);
      r_d   = $urandom;
      drive_st(r_stv, r_op, r_a, r_d);
      bus.mem_ack  = ($urandom_range(0, 99) < 45);
      bus.ld_valid = $urandom_range(0, 1);
      bus.ld_addr  = $urandom_range(0, 63);
      if (exp_q.size() > 0 && $urandom_range(0, 1) == 1)
        bus.ld_addr = {exp_q[$urandom_range(0, exp_q.size() - 1)][67:38], 2'($urandom)};
      #1;
      hz = 1'b0;
      foreach (exp_q[i]) if (exp_q[i][67:38] == bus.ld_addr[31:2]) hz = 1'b1;
      hz = hz & bus.ld_valid;
      chk("rnd_ready", bus.st_ready, exp_q.size() < DEPTH);
      chk("rnd_mem_req", bus.mem_req, exp_q.size() != 0);
      chk("rnd_buf_empty", bus.buf_empty, exp_q.size() == 0);
      chk("rnd_st_err", bus.st_err, m_err);
      chk("rnd_err_addr", bus.st_err_addr, m_err_addr);
      chk("rnd_hazard", bus.ld_hazard, hz);
      if (exp_q.size() != 0) begin
        chk("rnd_mem_addr", bus.mem_addr, exp_q[0][67:36]);
        chk("rnd_mem_wdata", bus.mem_wdata, exp_q[0][35:4]);
        chk("rnd_mem_be", bus.mem_be, exp_q[0][3:0]);
      end
      acc   = r_stv && (exp_q.size() < DEPTH);
      m_err = 1'b0;
      if (exp_q.size() != 0 && bus.mem_ack) void'(exp_q.pop_front());
      if (acc) begin
        if (model_legal(r_op, r_a)) begin
          exp_q.push_back({r_a[31:2], 2'b00, model_wdata(r_op, r_d), model_be(r_op, r_a)});
        end else begin
          m_err      = 1'b1;
          m_err_addr = r_a;
        end
      end
    end

    @(negedge clk);
    idle_inputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
